// File: rtl/uart_ctrl_pkg.sv
// Shared constants, FSM encoding and default-table helpers
// for the UART-driven threshold bank.
package uart_ctrl_pkg;

  localparam logic [7:0] CMD_INC      = "w";
  localparam logic [7:0] CMD_DEC      = "s";
  localparam logic [7:0] CMD_DEF      = "d";
  localparam logic [7:0] CMD_READ     = "r";
  localparam logic [7:0] CMD_SEL_BASE = "A";

  typedef enum logic [2:0] {
    S_IDLE,
    S_ECHO,
    S_APPLY,
    S_GAP,
    S_TX
  } state_t;

  localparam int MAX_FLAT = 26 * 32;

  localparam int K_MIN  = 0;
  localparam int K_MAX  = 1;
  localparam int K_STEP = 2;
  localparam int K_DEF  = 3;

  // Builds the stock per-channel tables: ch0, odd and even(>0) rows.
  function automatic logic [MAX_FLAT-1:0] def_vec(
    input int n,
    input int w,
    input int kind
  );
    logic [MAX_FLAT-1:0] r;
    logic [MAX_FLAT-1:0] m;
    int v;
    r = '0;
    m = (MAX_FLAT'(1) << w) - MAX_FLAT'(1);
    for (int i = 0; i < n; i++) begin
      case (kind)
        K_MIN:   v = (i == 0) ? 50   : (i % 2 == 1) ? 32 : -12;
        K_MAX:   v = (i == 0) ? 5000 : (i % 2 == 1) ? 50 : 27;
        K_STEP:  v = (i == 0) ? 50   : 1;
        default: v = (i == 0) ? 2550 : (i % 2 == 1) ? 35 : 16;
      endcase
      r |= (MAX_FLAT'(v) & m) << (i * w);
    end
    return r;
  endfunction

endpackage

// File: rtl/th_step_sat.sv
// Saturating step of one threshold value, signed or unsigned,
// evaluated two bits wider so the bound test never wraps.
module th_step_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] step,
  input  logic [W-1:0] min,
  input  logic [W-1:0] max,
  input  logic         is_signed,
  input  logic         dir,
  output logic [W-1:0] result
);

  localparam int XW = W + 2;

  logic signed [XW-1:0] v_x;
  logic signed [XW-1:0] s_x;
  logic signed [XW-1:0] lo_x;
  logic signed [XW-1:0] hi_x;
  logic signed [XW-1:0] sum_x;

  function automatic logic [XW-1:0] ext(
    input logic [W-1:0] x,
    input logic         sgn
  );
    return sgn ? {{2{x[W-1]}}, x} : {2'b00, x};
  endfunction

  always_comb begin
    v_x   = ext(value, is_signed);
    lo_x  = ext(min, is_signed);
    hi_x  = ext(max, is_signed);
    s_x   = {2'b00, step};
    sum_x = dir ? v_x + s_x : v_x - s_x;
    if (dir && sum_x > hi_x)
      result = max;
    else if (!dir && sum_x < lo_x)
      result = min;
    else
      result = sum_x[W-1:0];
  end

endmodule

// File: rtl/uart_threshold_bank.sv
// Bank of runtime-tunable thresholds driven by single-byte
// UART commands: select, inc, dec, restore default, readback.
module uart_threshold_bank
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 9,
  parameter int TH_WIDTH = 16,
  parameter logic [NUM_CH-1:0] SIGNED_MASK =
    NUM_CH'(9'h1FE),
  parameter logic [NUM_CH*TH_WIDTH-1:0] CH_MIN =
    (NUM_CH*TH_WIDTH)'(def_vec(NUM_CH, TH_WIDTH, K_MIN)),
  parameter logic [NUM_CH*TH_WIDTH-1:0] CH_MAX =
    (NUM_CH*TH_WIDTH)'(def_vec(NUM_CH, TH_WIDTH, K_MAX)),
  parameter logic [NUM_CH*TH_WIDTH-1:0] CH_STEP =
    (NUM_CH*TH_WIDTH)'(def_vec(NUM_CH, TH_WIDTH, K_STEP)),
  parameter logic [NUM_CH*TH_WIDTH-1:0] CH_DEFAULT =
    (NUM_CH*TH_WIDTH)'(def_vec(NUM_CH, TH_WIDTH, K_DEF))
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [NUM_CH*TH_WIDTH-1:0] th_flat,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] sel_ch,
  output logic                       th_updated,
  output logic                       cmd_dropped,
  output logic                       busy
);

  localparam int NUM_BYTES = TH_WIDTH / 8;
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES);

  state_t state, state_d;

  logic [TH_WIDTH-1:0] th [NUM_CH];
  logic [7:0] cmd_q;
  logic [2:0] byte_idx;

  logic [7:0] rx_rel, q_rel;
  logic rx_is_sel, rx_ok, q_is_sel, q_is_mod;

  logic [TH_WIDTH-1:0] cur, cur_step, cur_min, cur_max;
  logic [TH_WIDTH-1:0] cur_def, sat_res, th_new, cur_shift;

  logic       tx_start_d, upd_d;
  logic [7:0] tx_data_d;

  assign rx_rel    = rx_data - CMD_SEL_BASE;
  assign rx_is_sel = (rx_data >= CMD_SEL_BASE) &&
                     (rx_rel < 8'(NUM_CH));
  assign rx_ok     = rx_is_sel || (rx_data inside
                     {CMD_INC, CMD_DEC, CMD_DEF, CMD_READ});
  assign q_rel     = cmd_q - CMD_SEL_BASE;
  assign q_is_sel  = (cmd_q >= CMD_SEL_BASE) &&
                     (q_rel < 8'(NUM_CH));
  assign q_is_mod  = cmd_q inside {CMD_INC, CMD_DEC, CMD_DEF};

  assign cur       = th[sel_ch];
  assign cur_step  = CH_STEP[int'(sel_ch)*TH_WIDTH +: TH_WIDTH];
  assign cur_min   = CH_MIN[int'(sel_ch)*TH_WIDTH +: TH_WIDTH];
  assign cur_max   = CH_MAX[int'(sel_ch)*TH_WIDTH +: TH_WIDTH];
  assign cur_def   = CH_DEFAULT[int'(sel_ch)*TH_WIDTH +: TH_WIDTH];
  assign cur_shift = cur >> {byte_idx, 3'b000};
  assign th_new    = (cmd_q == CMD_DEF) ? cur_def : sat_res;
  assign busy      = (state != S_IDLE);

  th_step_sat #(.W(TH_WIDTH)) u_sat (
    .value     (cur),
    .step      (cur_step),
    .min       (cur_min),
    .max       (cur_max),
    .is_signed (SIGNED_MASK[sel_ch]),
    .dir       (cmd_q == CMD_INC),
    .result    (sat_res)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign th_flat[g*TH_WIDTH +: TH_WIDTH] = th[g];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (rx_valid && rx_ok) state_d = S_ECHO;
      S_ECHO:  if (tx_ready)
                 state_d = q_is_mod ? S_APPLY : S_GAP;
      S_APPLY: state_d = S_GAP;
      S_GAP:   state_d = (q_is_sel || byte_idx == LAST_IDX)
                         ? S_IDLE : S_TX;
      S_TX:    if (tx_ready) state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = cmd_q;
    upd_d      = 1'b0;
    unique case (state)
      S_ECHO:  tx_start_d = tx_ready;
      S_APPLY: upd_d = (th_new != cur);
      S_TX: begin
        tx_start_d = tx_ready;
        tx_data_d  = cur_shift[7:0];
      end
      default: ;
    endcase
  end

  // Datapath: tx registers, channel array, selection, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++)
        th[i] <= CH_DEFAULT[i*TH_WIDTH +: TH_WIDTH];
      sel_ch      <= '0;
      cmd_q       <= '0;
      byte_idx    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      th_updated  <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      tx_start   <= tx_start_d;
      th_updated <= upd_d;
      if (tx_start_d) tx_data <= tx_data_d;
      if (state == S_IDLE && rx_valid && rx_ok) begin
        cmd_q    <= rx_data;
        byte_idx <= '0;
      end
      if (state != S_IDLE && rx_valid) cmd_dropped <= 1'b1;
      if (state == S_ECHO && tx_ready && q_is_sel)
        sel_ch <= q_rel[$bits(sel_ch)-1:0];
      if (state == S_APPLY) th[sel_ch] <= th_new;
      if (state == S_TX && tx_ready) byte_idx <= byte_idx + 3'd1;
    end
  end

endmodule
